hazard_tracker: RTL and testbench

HAZARD_TRACKER -- requirements
Module: hazard_tracker

---
 rtl/hazard_tracker.sv | 112 +++++++++++
 tb/tb_hazard_tracker.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_tracker.sv
// Hazard tracker: follows destination/tnew through E, M and W and
// derives the D-stage stall and the rs/rt forwarding selects from it.
module hazard_tracker (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [1:0] d_tuse_rs,
    input  logic [1:0] d_tuse_rt,
    input  logic [4:0] d_wa,
    input  logic [1:0] d_tnew,
    output logic       stall,
    output logic [1:0] fwd_rs_sel,
    output logic [1:0] fwd_rt_sel,
    output logic [4:0] e_wa,
    output logic [4:0] m_wa,
    output logic [4:0] w_wa,
    output logic       w_we
);

    logic [4:0] eWa;
    logic [4:0] mWa;
    logic [4:0] wWa;
    logic [1:0] eTnew;
    logic [1:0] mTnew;
    logic [1:0] eTnewDec;
    logic       rsHazard;
    logic       rtHazard;

    // A producer stalls a consumer when its value arrives later than needed.
    function automatic logic srcHazard(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] wa,
        input logic [1:0] tnew
    );
        return (src != 5'd0) && (wa == src) && (tnew > tuse);
    endfunction

    // Youngest matching stage wins; a not-yet-ready match hides older ones.
    function automatic logic [1:0] srcFwd(
        input logic [4:0] src,
        input logic [4:0] ewa,
        input logic [1:0] etnew,
        input logic [4:0] mwa,
        input logic [1:0] mtnew,
        input logic [4:0] wwa
    );
        logic [1:0] sel;
        sel = 2'd0;
        if (src == 5'd0) begin
            sel = 2'd0;
        end else if (ewa == src) begin
            sel = (etnew == 2'd0) ? 2'd1 : 2'd0;
        end else if (mwa == src) begin
            sel = (mtnew == 2'd0) ? 2'd2 : 2'd0;
        end else if (wwa == src) begin
            sel = 2'd3;
        end
        return sel;
    endfunction

    assign eTnewDec = (eTnew == 2'd0) ? 2'd0 : eTnew - 2'd1;

    // Stall when either source would read a value not produced in time.
    always_comb begin
        rsHazard = srcHazard(d_rs, d_tuse_rs, eWa, eTnew)
                 | srcHazard(d_rs, d_tuse_rs, mWa, mTnew);
        rtHazard = srcHazard(d_rt, d_tuse_rt, eWa, eTnew)
                 | srcHazard(d_rt, d_tuse_rt, mWa, mTnew);
        stall    = rsHazard | rtHazard;
    end

    // Forwarding selects for both D-stage sources.
    always_comb begin
        fwd_rs_sel = srcFwd(d_rs, eWa, eTnew, mWa, mTnew, wWa);
        fwd_rt_sel = srcFwd(d_rt, eWa, eTnew, mWa, mTnew, wWa);
    end

    // E takes the D instruction, or a bubble while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            eWa   <= 5'd0;
            eTnew <= 2'd0;
        end else if (stall) begin
            eWa   <= 5'd0;
            eTnew <= 2'd0;
        end else begin
            eWa   <= d_wa;
            eTnew <= d_tnew;
        end
    end

    // M and W always advance; tnew counts down without wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mWa   <= 5'd0;
            mTnew <= 2'd0;
            wWa   <= 5'd0;
        end else begin
            mWa   <= eWa;
            mTnew <= eTnewDec;
            wWa   <= mWa;
        end
    end

    assign e_wa = eWa;
    assign m_wa = mWa;
    assign w_wa = wWa;
    assign w_we = (wWa != 5'd0);

endmodule

// File: tb/tb_hazard_tracker.sv
// Bench for hazard_tracker: directed vector table, reset corner cases
// and random traffic against a producer-age reference model.
module tb_hazard_tracker;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] d_rs = 5'd0;
    logic [4:0] d_rt = 5'd0;
    logic [1:0] d_tuse_rs = 2'd3;
    logic [1:0] d_tuse_rt = 2'd3;
    logic [4:0] d_wa = 5'd0;
    logic [1:0] d_tnew = 2'd0;
    logic       stall;
    logic [1:0] fwd_rs_sel;
    logic [1:0] fwd_rt_sel;
    logic [4:0] e_wa;
    logic [4:0] m_wa;
    logic [4:0] w_wa;
    logic       w_we;

    hazard_tracker dut (
        .clk(clk),
        .reset(reset),
        .d_rs(d_rs),
        .d_rt(d_rt),
        .d_tuse_rs(d_tuse_rs),
        .d_tuse_rt(d_tuse_rt),
        .d_wa(d_wa),
        .d_tnew(d_tnew),
        .stall(stall),
        .fwd_rs_sel(fwd_rs_sel),
        .fwd_rt_sel(fwd_rt_sel),
        .e_wa(e_wa),
        .m_wa(m_wa),
        .w_wa(w_wa),
        .w_we(w_we)
    );

    always #5 clk = ~clk;

    int nVec = 0;
    int nErr = 0;

    task automatic chk(input string name, input int got, input int exp);
        nVec++;
        if (got != exp) begin
            nErr++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [1:0] tuseRs;
        logic [1:0] tuseRt;
        logic [4:0] wa;
        logic [1:0] tnew;
        logic       expStall;
        logic [1:0] expRsSel;
        logic [1:0] expRtSel;
        logic [4:0] expEwa;
        logic       expWwe;
    } vec_t;

    vec_t vecs[18];

    // Reference model: every issued producer remembers when it entered E.
    typedef struct {
        logic [4:0] wa;
        int         tnew;
        int         enter;
    } prod_t;

    prod_t q[$];
    int    cyc = 0;

    function automatic int remain(input prod_t p);
        int r;
        r = p.tnew - (cyc - p.enter);
        return (r < 0) ? 0 : r;
    endfunction

    function automatic logic mHaz(input logic [4:0] s, input int tuse);
        if (s == 5'd0) return 1'b0;
        foreach (q[i]) begin
            if ((cyc - q[i].enter) <= 1 && q[i].wa == s && remain(q[i]) > tuse)
                return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int mSel(input logic [4:0] s);
        if (s == 5'd0) return 0;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if ((cyc - q[i].enter) <= 2 && q[i].wa == s)
                return (remain(q[i]) == 0) ? (cyc - q[i].enter) + 1 : 0;
        end
        return 0;
    endfunction

    function automatic int mStageWa(input int age);
        foreach (q[i]) begin
            if (cyc - q[i].enter == age) return int'(q[i].wa);
        end
        return 0;
    endfunction

    logic expSt;
    int   expW;
    logic lastStall = 1'b0;
    logic rstNow;

    initial begin
        //       rs  rt tRs tRt wa tn  st rsS rtS eWa we
        vecs[0]  = '{0,  0, 3, 3, 8, 2, 0, 0, 0, 0,  0};
        vecs[1]  = '{8,  0, 1, 3, 10,1, 1, 0, 0, 8,  0};
        vecs[2]  = '{8,  0, 1, 3, 10,1, 0, 0, 0, 0,  0};
        vecs[3]  = '{8,  0, 3, 3, 0, 0, 0, 3, 0, 10, 1};
        vecs[4]  = '{10, 0, 0, 3, 9, 2, 0, 2, 0, 0,  0};
        vecs[5]  = '{0,  9, 3, 0, 0, 0, 1, 0, 0, 9,  1};
        vecs[6]  = '{0,  9, 3, 0, 0, 0, 1, 0, 0, 0,  0};
        vecs[7]  = '{0,  9, 3, 0, 0, 0, 0, 0, 3, 0,  1};
        vecs[8]  = '{0,  0, 3, 3, 5, 1, 0, 0, 0, 0,  0};
        vecs[9]  = '{5,  0, 1, 3, 0, 0, 0, 0, 0, 5,  0};
        vecs[10] = '{5,  0, 3, 3, 5, 1, 0, 2, 0, 0,  0};
        vecs[11] = '{5,  0, 0, 3, 0, 0, 1, 0, 0, 5,  1};
        vecs[12] = '{5,  0, 0, 3, 0, 0, 0, 2, 0, 0,  0};
        vecs[13] = '{5,  0, 3, 3, 31,0, 0, 3, 0, 0,  1};
        vecs[14] = '{31, 5, 0, 3, 0, 0, 0, 1, 0, 31, 0};
        vecs[15] = '{31, 0, 3, 3, 0, 2, 0, 2, 0, 0,  0};
        vecs[16] = '{0,  0, 0, 0, 0, 0, 0, 0, 0, 0,  1};
        vecs[17] = '{0,  0, 3, 3, 0, 0, 0, 0, 0, 0,  0};

        // Reset state before any clock edge.
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_rs_sel", fwd_rs_sel, 0);
        chk("rst_rt_sel", fwd_rt_sel, 0);
        chk("rst_e_wa", e_wa, 0);
        chk("rst_m_wa", m_wa, 0);
        chk("rst_w_wa", w_wa, 0);
        chk("rst_w_we", w_we, 0);
        @(negedge clk);
        reset = 1'b0;

        // Directed vector table.
        foreach (vecs[i]) begin
            @(negedge clk);
            d_rs = vecs[i].rs;
            d_rt = vecs[i].rt;
            d_tuse_rs = vecs[i].tuseRs;
            d_tuse_rt = vecs[i].tuseRt;
            d_wa = vecs[i].wa;
            d_tnew = vecs[i].tnew;
            #1;
            chk($sformatf("v%0d_stall", i), stall, vecs[i].expStall);
            chk($sformatf("v%0d_rs_sel", i), fwd_rs_sel, vecs[i].expRsSel);
            chk($sformatf("v%0d_rt_sel", i), fwd_rt_sel, vecs[i].expRtSel);
            chk($sformatf("v%0d_e_wa", i), e_wa, vecs[i].expEwa);
            chk($sformatf("v%0d_w_we", i), w_we, vecs[i].expWwe);
        end

        // Reset between edges while a load-use stall is in progress.
        @(negedge clk);
        d_rs = 5'd0; d_rt = 5'd0; d_tuse_rs = 2'd3; d_tuse_rt = 2'd3;
        d_wa = 5'd8; d_tnew = 2'd2;
        @(negedge clk);
        d_rs = 5'd8; d_tuse_rs = 2'd0; d_wa = 5'd0; d_tnew = 2'd0;
        #1;
        chk("ar_pre_stall", stall, 1);
        chk("ar_pre_e_wa", e_wa, 8);
        reset = 1'b1;
        #1;
        chk("ar_e_wa", e_wa, 0);
        chk("ar_stall", stall, 0);
        chk("ar_rs_sel", fwd_rs_sel, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("ar_post_stall", stall, 0);
        chk("ar_post_rs_sel", fwd_rs_sel, 0);
        chk("ar_post_m_wa", m_wa, 0);

        // Random traffic against the reference model.
        @(negedge clk);
        reset = 1'b1;
        #1;
        q.delete();
        @(negedge clk);
        reset = 1'b0;
        lastStall = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (!(lastStall && ($urandom % 4 != 0))) begin
                d_rs = ($urandom % 8 == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
                d_rt = ($urandom % 8 == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
                d_tuse_rs = 2'($urandom_range(0, 3));
                d_tuse_rt = 2'($urandom_range(0, 3));
                d_wa = ($urandom % 8 == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
                d_tnew = 2'($urandom_range(0, 2));
            end
            rstNow = ($urandom % 64 == 0);
            reset = rstNow;
            #1;
            if (rstNow) q.delete();
            while (q.size() > 0 && (cyc - q[0].enter) > 2) void'(q.pop_front());
            expSt = mHaz(d_rs, int'(d_tuse_rs)) | mHaz(d_rt, int'(d_tuse_rt));
            expW = mStageWa(2);
            chk("rnd_stall", stall, expSt);
            chk("rnd_rs_sel", fwd_rs_sel, mSel(d_rs));
            chk("rnd_rt_sel", fwd_rt_sel, mSel(d_rt));
            chk("rnd_e_wa", e_wa, mStageWa(0));
            chk("rnd_m_wa", m_wa, mStageWa(1));
            chk("rnd_w_wa", w_wa, expW);
            chk("rnd_w_we", w_we, (expW != 0) ? 1 : 0);
            cyc++;
            if (!rstNow && !expSt)
                q.push_back('{d_wa, int'(d_tnew), cyc});
            lastStall = expSt && !rstNow;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
